// File: rtl/click_pkg.sv
// rtl/click_pkg.sv - shared phase type, reset phase and occupancy width helper for click_pipe
package click_pkg;

    typedef logic phase_t;

    localparam phase_t PH_RST = 1'b0;

    // Bits needed to count 0..depth occupied stages
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/click_stage.sv
// rtl/click_stage.sv - one clocked click stage: phase flop, data register and fire logic
module click_stage
    import click_pkg::*;
#(
    parameter int DWIDTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  phase_t            prev_ph,
    input  phase_t            next_ph,
    input  logic [DWIDTH-1:0] din,
    output phase_t            ph,
    output logic [DWIDTH-1:0] dout
);

    phase_t            ph_q;
    phase_t            ph_d;
    logic [DWIDTH-1:0] d_q;
    logic [DWIDTH-1:0] d_d;
    logic              fire;

    // A token waits upstream and this stage has been released downstream
    assign fire = (prev_ph != ph_q) && (next_ph == ph_q);

    // Next state: flip phase and capture the upstream token on fire
    always_comb begin
        ph_d = ph_q;
        d_d  = d_q;
        if (fire) begin
            ph_d = ~ph_q;
            d_d  = din;
        end
    end

    // Phase and data registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q <= PH_RST;
            d_q  <= '0;
        end else begin
            ph_q <= ph_d;
            d_q  <= d_d;
        end
    end

    assign ph   = ph_q;
    assign dout = d_q;

endmodule

// File: rtl/click_pipe.sv
// rtl/click_pipe.sv - DEPTH-stage two-phase click pipeline with occupancy; CLICK_PIPE_SYNC_EN adds input synchronisers
module click_pipe
    import click_pkg::*;
#(
    parameter int DWIDTH = 2,
    parameter int DEPTH  = 4,
    parameter int CWIDTH = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_req,
    output logic              in_ack,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_req,
    input  logic              out_ack,
    output logic [CWIDTH-1:0] occ,
    output logic              full,
    output logic              empty
);

    phase_t in_req_s;
    phase_t out_ack_s;

`ifdef CLICK_PIPE_SYNC_EN
    logic [1:0] req_sync_q;
    logic [1:0] ack_sync_q;

    // Two-flop synchronisers for the foreign-domain phase inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sync_q <= {2{PH_RST}};
            ack_sync_q <= {2{PH_RST}};
        end else begin
            req_sync_q <= {req_sync_q[0], in_req};
            ack_sync_q <= {ack_sync_q[0], out_ack};
        end
    end

    assign in_req_s  = req_sync_q[1];
    assign out_ack_s = ack_sync_q[1];
`else
    assign in_req_s  = in_req;
    assign out_ack_s = out_ack;
`endif

    logic [DEPTH-1:0]  ph;
    logic [DEPTH-1:0]  prv;
    logic [DEPTH-1:0]  nxt;
    logic [DWIDTH-1:0] d     [DEPTH];
    logic [DWIDTH-1:0] din_w [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign prv[gi]   = in_req_s;
                assign din_w[gi] = in_data;
            end else begin : g_body
                assign prv[gi]   = ph[gi-1];
                assign din_w[gi] = d[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign nxt[gi] = out_ack_s;
            end else begin : g_link
                assign nxt[gi] = ph[gi+1];
            end

            click_stage #(
                .DWIDTH (DWIDTH)
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .prev_ph (prv[gi]),
                .next_ph (nxt[gi]),
                .din     (din_w[gi]),
                .ph      (ph[gi]),
                .dout    (d[gi])
            );
        end
    endgenerate

    // A stage holds a token while its phase differs from its downstream neighbour
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + CWIDTH'(ph[k] ^ nxt[k]);
        end
    end

    assign full     = (occ == CWIDTH'(DEPTH));
    assign empty    = (occ == '0);
    assign in_ack   = ph[0];
    assign out_req  = ph[DEPTH-1];
    assign out_data = d[DEPTH-1];

endmodule

// File: tb/tb_click_pipe.sv
// tb/tb_click_pipe.sv - randomized self-checking bench for click_pipe against a token-level model
module tb_click_pipe;

    localparam int DWIDTH = 2;
    localparam int DEPTH  = 4;
    localparam int CWIDTH = $clog2(DEPTH + 1);
`ifdef CLICK_PIPE_SYNC_EN
    localparam int SLAT = 2;
`else
    localparam int SLAT = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DWIDTH-1:0] in_data = '0;
    logic              in_req = 1'b0;
    logic              in_ack;
    logic [DWIDTH-1:0] out_data;
    logic              out_req;
    logic              out_ack = 1'b0;
    logic [CWIDTH-1:0] occ;
    logic              full;
    logic              empty;

    click_pipe #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .out_data (out_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .occ      (occ),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Token-level model: which stages hold a token and what it is
    bit                m_valid [DEPTH];
    logic [DWIDTH-1:0] m_data  [DEPTH];
    bit                m_in_ack;
    bit                m_out_req;
    bit   [1:0]        req_h;
    bit   [1:0]        ack_h;
    logic [DWIDTH-1:0] sent [$];
    int                n_recv;

    function automatic bit req_seen();
        return (SLAT == 0) ? in_req : req_h[1];
    endfunction

    function automatic bit ack_seen();
        return (SLAT == 0) ? out_ack : ack_h[1];
    endfunction

    function automatic bit holds(input int i);
        if (i == DEPTH - 1) return m_out_req != ack_seen();
        return m_valid[i];
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += holds(i) ? 1 : 0;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        m_in_ack  = 1'b0;
        m_out_req = 1'b0;
        req_h     = '0;
        ack_h     = '0;
    endtask

    // Advance the model across one rising edge using the pre-edge inputs
    task automatic model_edge();
        bit                had  [DEPTH];
        bit                move [DEPTH];
        logic [DWIDTH-1:0] old  [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            had[i] = holds(i);
            old[i] = m_data[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            bit src = (i == 0) ? (req_seen() != m_in_ack) : had[i-1];
            move[i] = src && !had[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (move[i]) begin
                m_data[i] = (i == 0) ? in_data : old[i-1];
                if (i < DEPTH - 1) m_valid[i] = 1'b1;
                if (i > 0) m_valid[i-1] = 1'b0;
                if (i == 0) m_in_ack = ~m_in_ack;
                if (i == DEPTH - 1) m_out_req = ~m_out_req;
            end
        end
        req_h = {req_h[0], in_req};
        ack_h = {ack_h[0], out_ack};
    endtask

    task automatic check_outputs();
        int o = m_occ();
        check("in_ack", in_ack, m_in_ack);
        check("out_req", out_req, m_out_req);
        check("out_data", out_data, m_data[DEPTH-1]);
        check("occ", occ, o);
        check("full", full, o == DEPTH);
        check("empty", empty, o == 0);
    endtask

    // Inputs are already driven for this cycle; check, then cross one edge
    task automatic step();
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_req  = 1'b0;
        out_ack = 1'b0;
        in_data = '0;
        model_clear();
        sent.delete();
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ack", in_ack, 0);
        check("rst_out_req", out_req, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occ", occ, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Randomized producer/consumer obeying the two-phase protocol
    task automatic run(input int cycles, input int prod_pct, input int cons_pct, input int max_send);
        int n_sent = 0;
        for (int c = 0; c < cycles; c++) begin
            if (in_req == m_in_ack && n_sent < max_send && $urandom_range(99) < prod_pct) begin
                in_data = DWIDTH'($urandom);
                in_req  = ~in_req;
                sent.push_back(in_data);
                n_sent++;
            end
            if (out_ack != m_out_req && $urandom_range(99) < cons_pct) begin
                if (sent.size() == 0) check("order_underflow", 1, 0);
                else check("order", out_data, sent.pop_front());
                n_recv++;
                out_ack = ~out_ack;
            end
            step();
        end
    endtask

    task automatic send(input logic [DWIDTH-1:0] v);
        int guard = 0;
        while (in_req != m_in_ack && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check("send_timeout", 0, 1);
        in_data = v;
        in_req  = ~in_req;
        sent.push_back(v);
    endtask

    initial begin
        model_clear();
        n_recv = 0;
        do_reset();

        // Single token latency
        in_data = 2'b10;
        in_req  = 1'b1;
        sent.push_back(2'b10);
        for (int e = 1; e <= DEPTH + SLAT; e++) begin
            step();
            if (e == SLAT) check("ack_before", in_ack, 0);
            if (e == 1 + SLAT) check("ack_lat", in_ack, 1);
            if (e == DEPTH + SLAT - 1) check("req_before", out_req, 0);
        end
        check("req_lat", out_req, 1);
        check("req_data", out_data, 2'b10);
        check("single_occ", occ, 1);
        out_ack = 1'b1;
        void'(sent.pop_front());
        repeat (SLAT + 1) step();
        check("single_drained", occ, 0);

        // Fill to capacity with the consumer stalled
        do_reset();
        send(2'b01);
        send(2'b10);
        send(2'b11);
        send(2'b00);
        repeat (DEPTH + SLAT + 2) step();
        check("fill_full", full, 1);
        check("fill_occ", occ, DEPTH);
        send(2'b01);
        repeat (SLAT + 4) step();
        check("blocked_ack", in_ack, 0);
        check("blocked_occ", occ, DEPTH);

        // Drain in order; the blocked fifth token follows
        n_recv = 0;
        run(80, 0, 100, 0);
        check("drain_count", n_recv, 5);
        check("drain_occ", occ, 0);
        check("drain_empty", empty, 1);

        // Asynchronous reset with two tokens in flight
        do_reset();
        send(2'b11);
        send(2'b01);
        repeat (DEPTH + SLAT + 2) step();
        check("pre_rst_occ", occ, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_in_ack", in_ack, 0);
        check("arst_out_req", out_req, 0);
        check("arst_out_data", out_data, 0);
        check("arst_occ", occ, 0);
        check("arst_empty", empty, 1);
        do_reset();

        // Random traffic then drain
        n_recv = 0;
        run(400, 60, 50, 1000);
        run(100, 0, 100, 0);
        check("rand_drained", sent.size(), 0);
        check("rand_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/click_pipe.md
Name: click_pipe

Overview:
- Parametrised, clocked successor to the single-stage click buffer.
- Chain of DEPTH click stages carrying DWIDTH-bit tokens between a producer and a consumer.
- Both sides use a two-phase (transition) req/ack handshake.
- Adds depth, width, occupancy status and optional input synchronisers. Sits between loosely-coupled blocks that need elastic buffering with transition signalling.

Parameters:
- DWIDTH, 2: token data width in bits, >=1.
- DEPTH, 4: number of stages and token capacity, >=1.
- CWIDTH, $clog2(DEPTH+1): width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  DWIDTH  producer token; held stable while in_req != in_ack.
- in_req  input  1  producer phase; a toggle presents a new token.
- in_ack  output  1  acceptance phase; toggles when stage 0 captures a token.
- out_data  output  DWIDTH  token held in the last stage.
- out_req  output  1  output phase; toggles when a new token reaches the last stage.
- out_ack  input  1  consumer phase; a toggle releases the last stage.
- occ  output  CWIDTH  number of occupied stages, 0..DEPTH.
- full  output  1  occ == DEPTH.
- empty  output  1  occ == 0.

Behaviour:
- State per stage i: phase bit ph[i], data register d[i].
- Neighbour definitions:
  - prev(i) = in_req for i = 0, else ph[i-1].
  - next(i) = out_ack for i = DEPTH-1, else ph[i+1].
  - din(i) = in_data for i = 0, else d[i-1].
- Fire rule: fire[i] = (prev(i) != ph[i]) && (next(i) == ph[i]). Evaluated on pre-edge values.
- On fire[i]: ph[i] <= ~ph[i]; d[i] <= din(i). Otherwise ph[i] and d[i] hold.
- Adjacent stages can never fire on the same edge, because their fire conditions are mutually exclusive. Non-adjacent stages fire concurrently.
- Outputs:
  - in_ack = ph[0]; out_req = ph[DEPTH-1]; out_data = d[DEPTH-1].
  - All registered, no combinational path from inputs.
- Occupancy:
  - Stage i is full iff ph[i] != next(i).
  - occ = count of full stages, combinational from registered phases and out_ack.
  - full and empty are decoded from occ.
- Latency:
  - in_req toggle sampled at edge E into an empty pipe: in_ack toggles after E; out_req toggles after edge E+DEPTH-1.
  - out_ack toggle on a full pipe: stage DEPTH-1 can accept a new token at the next edge. Bubbles propagate backward one stage per edge.
- Capacity: DEPTH tokens.
  - When full, further in_req toggles are not captured and in_ack holds until space frees.
  - When empty, out_req == out_ack.
- Protocol obligations (not checked in RTL):
  - Producer toggles in_req only while in_req == in_ack.
  - Consumer toggles out_ack only while out_ack != out_req.
- Reset (reset_n low, asynchronous):
  - All ph[i] = 0, all d[i] = 0.
  - Hence in_ack = 0, out_req = 0, out_data = 0, occ = 0, empty = 1, full = 0.
  - Mid-operation reset discards all tokens. Producer and consumer must also return their phases to 0.
- DEPTH = 1: a single stage; behaviour reduces to the original one-stage click buffer, clocked.

Optional Feature:
- Macro: CLICK_PIPE_SYNC_EN.
- Defined:
  - in_req and out_ack each pass through a 2-flop synchroniser (reset to 0 by reset_n) before use in fire and occ.
  - Adds 2 cycles to input acceptance and to output release.
  - in_data stability is guaranteed by the two-phase protocol.
  - Intended for producers and consumers in other clock domains.
- Undefined: in_req and out_ack are used directly. Latencies are as stated under Behaviour.

Decomposition:
- Shared package click_pkg:
  - phase type (1 bit) and reset phase constant PH_RST = 0.
  - function for the occupancy width.
- One natural sub-module, click_stage: phase flop, data register and fire logic. Instantiated DEPTH times with a generate loop.
- Occupancy counter and optional synchronisers live in the top.

Test Plan:
- Reset: hold reset_n = 0, then release. Required: in_ack = 0, out_req = 0, out_data = 0, occ = 0, empty = 1.
- Single token, DEPTH = 4, DWIDTH = 2: in_data = 2'b10, toggle in_req to 1. Required: in_ack = 1 after the first edge; out_req = 1 with out_data = 2'b10 after edge 4; occ = 1 throughout; out_ack -> 1 gives occ = 0.
- Fill to capacity: out_ack held, send 2'b01, 2'b10, 2'b11, 2'b00. Required: full = 1, occ = 4; a fifth in_req toggle leaves in_ack unchanged.
- Drain in order: from the full state, toggle out_ack after each out_req toggle. Required: tokens 01, 10, 11, 00 in order; the fifth token is accepted after the first release; occ ends at 0.
- Reset mid-operation: with occ = 2, pulse reset_n low between edges. Required: immediate asynchronous clear, all outputs at reset values.
- CLICK_PIPE_SYNC_EN defined: repeat the single-token case. Required: in_ack toggles 2 cycles later and out_req after edge 6.
